prewish_mentor_seq: RTL
=======================

// Module: prewish_mentor_seq
// PURPOSE
//  Parametrised successor to the single-shot mentor: plays a compile-time table of NUM_WORDS mask words, DATA_W
//  bits each, to a downstream blinker. Each word is driven on DAT_O one cycle before STB_O rises. STB_O holds until
//  ACK_I, then a programmable gap follows before the next word. Sits between top-level start logic and the blinker.
// PARAMETERS
//  DATA_W      8                         width of each mask word / DAT_O
//  NUM_WORDS   4                         table depth; legal range 1..256
//  MASKS       {8'h81,8'h3C,8'h0F,8'hA0} packed table, NUM_WORDS*DATA_W bits; word 0 = LSBs (8'hA0 sent first)
//  GAP_CYCLES  16                        idle cycles between ACK and next SETUP; 0 = no gap state
//  AUTO_START  1                         1 = start automatically once after reset release; 0 = wait for START_I
// PORTS
//  CLK_I    in   1                        single clock, rising edge
//  RST_I    in   1                        synchronous, active-high reset
//  START_I  in   1                        start pulse; sampled only in IDLE
//  ACK_I    in   1                        word accepted; meaningful only while STB_O=1
//  STB_O    out  1                        word-valid strobe
//  DAT_O    out  DATA_W                   current mask word
//  IDX_O    out  IW=max(1,$clog2(NUM_WORDS)) index of word on DAT_O
//  BUSY_O   out  1                        high in every state except IDLE and DONE
//  DONE_O   out  1                        high in DONE (sticky until reset or next START_I)
// BEHAVIOUR
//  Reset (any cycle, incl. mid-handshake): next edge -> state IDLE, STB_O=0, DAT_O=0, IDX_O=0, BUSY_O=0, DONE_O=0,
//   gap counter=0. All outputs registered.
//  IDLE:     START_I=1, or first non-reset cycle when AUTO_START=1 -> SETUP.
//  SETUP:    DAT_O<=MASKS[idx], IDX_O<=idx -> STROBE. Data stable >=1 cycle before STB_O rises.
//  STROBE:   STB_O<=1 -> WAIT_ACK.
//  WAIT_ACK: hold STB_O and DAT_O while ACK_I=0 (no timeout). On ACK_I=1: STB_O<=0;
//            if idx==NUM_WORDS-1 -> DONE (or wrap, see CONFIGURATION), else idx+1 -> GAP (SETUP if GAP_CYCLES=0).
//  GAP:      count 0..GAP_CYCLES-1, then -> SETUP. DAT_O keeps last word.
//  DONE:     DONE_O=1, STB_O=0. START_I=1 -> clear DONE_O, idx=0 -> SETUP (replay).
//  Latency:  START_I at edge N -> DAT_O at N+1 -> STB_O at N+2. ACK at edge M -> STB_O low at M+1.
//  Single-word handshake: ACK_I in the first STB_O=1 cycle ends the handshake; STB_O high exactly one cycle.
//  ACK_I while STB_O=0 ignored. START_I while BUSY_O=1 ignored. ACK_I and START_I together: ACK wins.
//  Index wrap: idx never exceeds NUM_WORDS-1. NUM_WORDS=1 -> IW=1, idx stays 0.
//  GAP counter width $clog2(GAP_CYCLES+1); no overflow possible.
// CONFIGURATION
//  PREWISH_MENTOR_LOOP_EN defined: after ACK of last word, idx<=0 -> GAP (or SETUP); sequence repeats forever.
//   DONE unreachable; DONE_O tied 0; only RST_I stops playback.
//  Not defined: one pass per start, end in DONE as above.
// STRUCTURE
//  Package prewish_pkg: state enum (IDLE,SETUP,STROBE,WAIT_ACK,GAP,DONE), 3-bit encoding, IDLE=3'd0;
//   localparam function for IW. Packed-table slicing helper also lives there.
//  Sub-module prewish_gap_timer: load/count/expire down-counter, param GAP_CYCLES, reused by other blinky blocks.
//  Top holds FSM, index register, output registers.
// TESTING  (DATA_W=8, NUM_WORDS=2, MASKS={8'h0F,8'hA0}, GAP_CYCLES=3, unless noted)
//  1 Reset then release, AUTO_START=1, ACK_I=1 -> DAT_O=A0 at cycle 1, STB_O cycles 2 only, gap 3 cycles,
//    DAT_O=0F then STB_O 1 cycle, DONE_O=1, BUSY_O=0.
//  2 ACK_I held low 10 cycles then pulsed -> STB_O high 11 cycles, DAT_O stable A0 throughout, falls next edge.
//  3 AUTO_START=0, START_I pulse mid-GAP and in IDLE -> ignored mid-run; from IDLE DAT_O at +1, STB_O at +2.
//  4 RST_I asserted during WAIT_ACK with STB_O=1 -> next edge STB_O=0, DAT_O=00, IDX_O=0, IDLE; replay from A0.
//  5 In DONE, START_I=1 -> DONE_O clears, sequence A0,0F replays identically.
//  6 PREWISH_MENTOR_LOOP_EN, ACK_I=1 -> A0,0F,A0,0F... with 3-cycle gaps; DONE_O never 1; GAP_CYCLES=0 run:
//    STB_O period exactly 3 cycles.

Source files
------------

// File: rtl/prewish_mentor_seq_pkg.sv
// prewish_pkg: shared state encoding and sizing/slicing helpers for the mask-word player.
// Revision: 1.0
`default_nettype none

package prewish_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_STROBE   = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_GAP      = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  function automatic int calc_iw(input int num_words);
    return (num_words > 1) ? $clog2(num_words) : 1;
  endfunction

  // Bit offset of word idx inside a packed table with word 0 in the LSBs.
  function automatic int word_lsb(input int idx, input int data_w);
    return idx * data_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prewish_mentor_seq_gap_timer.sv
// prewish_gap_timer: load/count/expire down-counter giving a GAP_CYCLES-cycle idle window.
// Revision: 1.0
`default_nettype none

module prewish_gap_timer #(
  parameter int GAP_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int unsigned LOADV = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(LOADV);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/prewish_mentor_seq.sv
// prewish_mentor_seq: plays a packed table of mask words to a blinker over a STB/ACK handshake.
// Optional macro PREWISH_MENTOR_LOOP_EN replays the table forever instead of stopping in DONE. Revision: 1.0
`default_nettype none

module prewish_mentor_seq
  import prewish_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_WORDS  = 4,
  parameter logic [NUM_WORDS*DATA_W-1:0] MASKS = {8'h81, 8'h3C, 8'h0F, 8'hA0},
  parameter int GAP_CYCLES = 16,
  parameter int AUTO_START = 1
) (
  input  logic                                CLK_I,
  input  logic                                RST_I,
  input  logic                                START_I,
  input  logic                                ACK_I,
  output logic                                STB_O,
  output logic [DATA_W-1:0]                   DAT_O,
  output logic [calc_iw(NUM_WORDS)-1:0]       IDX_O,
  output logic                                BUSY_O,
  output logic                                DONE_O
);

  localparam int IW = calc_iw(NUM_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);
  localparam state_t POST_ACK = (GAP_CYCLES > 0) ? S_GAP : S_SETUP;

  state_t              r_state;
  logic [IW-1:0]       r_idx;
  logic                r_auto_pend;
  logic                r_stb;
  logic [DATA_W-1:0]   r_dat;
  logic [IW-1:0]       r_idx_o;
  logic                r_busy;
  logic                r_done;

  logic                w_ack;
  logic                w_last;
  logic                w_gap_expire;
  logic [DATA_W-1:0]   w_word;

  assign w_ack  = (r_state == S_WAIT_ACK) && ACK_I;
  assign w_last = (r_idx == LAST_IDX);
  assign w_word = MASKS[word_lsb(int'(r_idx), DATA_W) +: DATA_W];

  generate
    if (GAP_CYCLES > 0) begin : g_gap_timer
      prewish_gap_timer #(
        .GAP_CYCLES (GAP_CYCLES)
      ) u_gap_timer (
        .clk      (CLK_I),
        .rst      (RST_I),
        .i_load   (w_ack),
        .i_en     (r_state == S_GAP),
        .o_expire (w_gap_expire)
      );
    end else begin : g_no_gap
      assign w_gap_expire = 1'b1;
    end
  endgenerate

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_auto_pend <= 1'b1;
      r_stb       <= 1'b0;
      r_dat       <= '0;
      r_idx_o     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Auto-start fires once per reset release; later starts need START_I.
          if (START_I || ((AUTO_START != 0) && r_auto_pend)) begin
            r_state     <= S_SETUP;
            r_idx       <= '0;
            r_busy      <= 1'b1;
            r_auto_pend <= 1'b0;
          end
        end
        S_SETUP: begin
          r_dat   <= w_word;
          r_idx_o <= r_idx;
          r_state <= S_STROBE;
        end
        S_STROBE: begin
          r_stb   <= 1'b1;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (ACK_I) begin
            r_stb <= 1'b0;
            if (w_last) begin
`ifdef PREWISH_MENTOR_LOOP_EN
              r_idx   <= '0;
              r_state <= POST_ACK;
`else
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
`endif
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= POST_ACK;
            end
          end
        end
        S_GAP: begin
          if (w_gap_expire) begin
            r_state <= S_SETUP;
          end
        end
        S_DONE: begin
          if (START_I) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_state <= S_SETUP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign STB_O  = r_stb;
  assign DAT_O  = r_dat;
  assign IDX_O  = r_idx_o;
  assign BUSY_O = r_busy;
  assign DONE_O = r_done;

endmodule

`default_nettype wire
